// File: rtl/stupidrv_dmem_bridge.sv
// ============================================================================
// Module   : stupidrv_dmem_bridge
// Purpose  : Data-memory stage behind the stupidrv core. Turns the core's
//            single-cycle dmem request into a registered valid/ready bus
//            transaction and stalls the core until it completes. Read data
//            is returned in the one-cycle DONE slot where the core commits.
// Revision : 1.0 - initial release
//
// Ports
//   clock, resetn          : clock, asynchronous active-low reset
//   cpu_valid/addr/wstrb/wdata : core request (wstrb == 0 means read)
//   cpu_rdata              : read data to the core (holds between accesses)
//   cpu_stall              : core stall
//   bus_valid/addr/wstrb/wdata : registered request to memory
//   bus_ready, bus_rdata   : memory handshake / read data
//   bus_err                : one-cycle pulse on watchdog abort
//
// Optional feature macro: DMEM_BRIDGE_TIMEOUT_EN
//   Defined   : 16-bit BUSY watchdog; after TIMEOUT_CYCLES BUSY cycles
//               without bus_ready the access is aborted, reads return
//               ERR_RDATA and bus_err pulses. TIMEOUT_CYCLES (2..65535)
//               and ERR_RDATA exist only in this build.
//   Undefined : no watchdog, bus_err tied 0, BUSY waits indefinitely.
// ============================================================================
`default_nettype none

module stupidrv_dmem_bridge #(
  parameter logic [31:0] RESET_RDATA = 32'h0000_0000
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 256
  , parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
`endif
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_valid,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_wstrb,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        bus_valid_q, bus_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] wdog_q, wdog_d;
  logic        bus_err_q, bus_err_d;
`endif

  // Stall is combinational in IDLE so the core never commits in the cycle
  // it raises a request; DONE is the core's commit slot and never stalls.
  assign cpu_stall = (state_q == ST_BUSY) || ((state_q == ST_IDLE) && cpu_valid);

  assign bus_valid = bus_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;
  assign cpu_rdata = cpu_rdata_q;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_valid_d = bus_valid_q;
    bus_addr_d  = bus_addr_q;
    bus_wstrb_d = bus_wstrb_q;
    bus_wdata_d = bus_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    wdog_d      = wdog_q;
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        // Request fields are captured only here; later core-side changes
        // cannot disturb an outstanding bus access.
        if (cpu_valid) begin
          bus_addr_d  = cpu_addr;
          bus_wstrb_d = cpu_wstrb;
          bus_wdata_d = cpu_wdata;
          bus_valid_d = 1'b1;
          state_d     = ST_BUSY;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
          wdog_d      = 16'd0;
`endif
        end
      end

      ST_BUSY: begin
        // A handshake always takes priority over a watchdog expiry that
        // lands on the same cycle.
        if (bus_valid_q && bus_ready) begin
          if (bus_wstrb_q == 4'b0000) begin
            cpu_rdata_d = bus_rdata;
          end
          bus_valid_d = 1'b0;
          state_d     = ST_DONE;
        end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
        else if ((wdog_q + 16'd1) == TIMEOUT_LIMIT) begin
          if (bus_wstrb_q == 4'b0000) begin
            cpu_rdata_d = ERR_RDATA;
          end
          bus_valid_d = 1'b0;
          bus_err_d   = 1'b1;
          wdog_d      = wdog_q + 16'd1;
          state_d     = ST_DONE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end

      ST_DONE: begin
        // The core still presents the same instruction here; cpu_valid is
        // deliberately ignored so it is not issued twice.
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bus_valid_q <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wstrb_q <= 4'h0;
      bus_wdata_q <= 32'h0;
      cpu_rdata_q <= RESET_RDATA;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      wdog_q      <= 16'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_valid_q <= bus_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wstrb_q <= bus_wstrb_d;
      bus_wdata_q <= bus_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
      wdog_q      <= wdog_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stupidrv_dmem_bridge.sv
// ============================================================================
// Module   : tb_stupidrv_dmem_bridge
// Purpose  : Self-checking bench for stupidrv_dmem_bridge. A core agent
//            issues requests, a memory agent answers after a chosen number
//            of wait cycles, and a transaction-level model predicts the
//            stall length, bus activity and returned read data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stupidrv_dmem_bridge;

  localparam logic [31:0] RST_RDATA = 32'h0000_0000;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
  localparam int          TO_CYCLES = 4;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;
  localparam int          MAX_WAIT  = 3;
`else
  localparam int          MAX_WAIT  = 6;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        cpu_valid;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_wstrb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        bus_valid;
  logic        bus_ready;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_rdata;

  always #5 clock = ~clock;

  stupidrv_dmem_bridge #(
    .RESET_RDATA   (RST_RDATA)
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO_CYCLES)
    , .ERR_RDATA     (ERR_DATA)
`endif
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wstrb (cpu_wstrb),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .bus_valid (bus_valid),
    .bus_ready (bus_ready),
    .bus_addr  (bus_addr),
    .bus_wstrb (bus_wstrb),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_err   (bus_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete core access. Entered just after a rising edge with the
  // bridge expected in IDLE; returns at the falling edge of the commit
  // (non-stalled) cycle.
  task automatic do_txn(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input int waits, input logic [31:0] rd, input bit timeout);
    int  stalls = 0;
    int  bv     = 0;
    int  cyc    = 0;
    bit  done   = 1'b0;
    int  exp_stalls;
    int  exp_bv;
    cpu_valid = 1'b1;
    cpu_addr  = a;
    cpu_wstrb = s;
    cpu_wdata = d;
    bus_ready = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (cpu_stall) begin
        stalls++;
        if (bus_valid) begin
          check("bus_addr",  bus_addr, a);
          check("bus_wstrb", {28'd0, bus_wstrb}, {28'd0, s});
          check("bus_wdata", bus_wdata, d);
          if (!timeout && bv == waits) begin
            bus_ready = 1'b1;
            bus_rdata = rd;
          end else begin
            bus_ready = 1'b0;
            bus_rdata = $urandom;
          end
          bv++;
          // Request already latched: core-side changes must be ignored.
          cpu_addr  = $urandom;
          cpu_wdata = $urandom;
        end
      end else begin
        done = 1'b1;
      end
    end
    bus_ready = 1'b0;
    if (!done) begin
      check("txn_budget", 32'd1, 32'd0);
    end
    // Core keeps presenting the same instruction in its commit cycle.
    cpu_addr  = a;
    cpu_wdata = d;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    if (timeout) begin
      exp_stalls = 1 + TO_CYCLES;
      exp_bv     = TO_CYCLES;
      if (s == 4'b0000) model_rdata = ERR_DATA;
    end else
`endif
    begin
      exp_stalls = 2 + waits;
      exp_bv     = waits + 1;
      if (s == 4'b0000) model_rdata = rd;
    end
    check("stall_cycles", 32'(stalls), 32'(exp_stalls));
    check("bus_valid_cycles", 32'(bv), 32'(exp_bv));
    check("cpu_rdata", cpu_rdata, model_rdata);
    check("bus_valid_done", {31'd0, bus_valid}, 32'd0);
    check("bus_err", {31'd0, bus_err}, {31'd0, timeout});
  endtask

  task automatic idle_cycles(input int n);
    cpu_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      cpu_addr = $urandom;
      @(negedge clock);
      check("idle_stall", {31'd0, cpu_stall}, 32'd0);
      check("idle_bus_valid", {31'd0, bus_valid}, 32'd0);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    resetn    = 1'b0;
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_0040;
    cpu_wstrb = 4'b0000;
    cpu_wdata = 32'h0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
    model_rdata = RST_RDATA;

    // Reset held with a pending request: only the combinational stall shows.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_stall", {31'd0, cpu_stall}, 32'd1);
    check("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, RST_RDATA);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    do_txn(32'h0000_0040, 4'b0000, 32'h0, 0, 32'h0BAD_F00D, 1'b0);
    @(posedge clock); #1;

    // Read, zero wait.
    do_txn(32'h0000_0100, 4'b0000, 32'h0, 0, 32'h1234_5678, 1'b0);
    @(posedge clock); #1;
    idle_cycles(1);

    // Write with three wait cycles; read data must be left alone.
    do_txn(32'h0000_0200, 4'b0011, 32'hAAAA_5555, 3, 32'hFFFF_FFFF, 1'b0);
    @(posedge clock); #1;
    idle_cycles(2);

    // Back-to-back SW then LW with cpu_valid held throughout.
    do_txn(32'h0000_0300, 4'b1111, 32'h0102_0304, 1, 32'h0, 1'b0);
    @(posedge clock); #1;
    do_txn(32'h0000_0304, 4'b0000, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
    @(posedge clock); #1;
    idle_cycles(1);

    // Asynchronous reset while waiting on the bus.
    cpu_valid = 1'b1;
    cpu_addr  = 32'h0000_0400;
    cpu_wstrb = 4'b0000;
    bus_ready = 1'b0;
    repeat (3) @(negedge clock);
    #2;
    resetn = 1'b0;
    #1;
    model_rdata = RST_RDATA;
    check("arst_bus_valid", {31'd0, bus_valid}, 32'd0);
    check("arst_bus_addr", bus_addr, 32'd0);
    check("arst_cpu_rdata", cpu_rdata, model_rdata);
    cpu_valid = 1'b0;
    #1;
    check("arst_stall", {31'd0, cpu_stall}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(negedge clock);
    check("arst_no_done_stall", {31'd0, cpu_stall}, 32'd0);
    check("arst_no_done_valid", {31'd0, bus_valid}, 32'd0);
    check("arst_no_done_err", {31'd0, bus_err}, 32'd0);
    @(posedge clock); #1;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    do_txn(32'h0000_0500, 4'b0000, 32'h0, 0, 32'h0, 1'b1);
    @(posedge clock); #1;
    idle_cycles(1);
`endif

    // Randomized traffic against the transaction model.
    for (int k = 0; k < 60; k++) begin
      int          gap;
      int          w;
      logic [3:0]  s;
      gap = int'($urandom_range(0, 2));
      if (gap > 0) idle_cycles(gap);
      w = int'($urandom_range(0, MAX_WAIT));
      s = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      do_txn($urandom, s, $urandom, w, $urandom, 1'b0);
      @(posedge clock); #1;
    end
    idle_cycles(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/stupidrv_dmem_bridge.md
Name: stupidrv_dmem_bridge

Overview:
Data-memory stage directly downstream of the stupidrv core. Consumes the core's single-cycle dmem request (valid/addr/wstrb/wdata) and converts it into a registered valid/ready bus transaction to a multi-cycle memory. Drives the core's stall input while the transaction is outstanding, then returns read data during the core's commit cycle.

Parameters:
RESET_RDATA, 32'h0000_0000, reset value of cpu_rdata
TIMEOUT_CYCLES, 256, watchdog limit in BUSY cycles (used only with DMEM_BRIDGE_TIMEOUT_EN); legal range 2..65535
ERR_RDATA, 32'hDEAD_BEEF, read data returned on timeout abort

Ports:
clock  input  1  single clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
cpu_valid  input  1  core dmem_valid
cpu_addr  input  32  core dmem_addr
cpu_wstrb  input  4  core dmem_wstrb; 0 = read
cpu_wdata  input  32  core dmem_wdata
cpu_rdata  output  32  read data to core dmem_rdata
cpu_stall  output  1  to core stall input
bus_valid  output  1  request valid to memory
bus_ready  input  1  memory accepts/completes request
bus_addr  output  32  latched address
bus_wstrb  output  4  latched byte strobes
bus_wdata  output  32  latched write data
bus_rdata  input  32  memory read data, valid when bus_valid && bus_ready
bus_err  output  1  one-cycle pulse on timeout abort (tied 0 without feature)

Behaviour:
- Asynchronous reset (resetn low): state=IDLE; bus_valid=0; bus_addr/bus_wstrb/bus_wdata=0; cpu_rdata=RESET_RDATA; bus_err=0; watchdog=0. Takes effect immediately, mid-transaction included; in-flight request is dropped without handshake.
- States: IDLE, BUSY, DONE.
- IDLE: cpu_stall = cpu_valid (combinational, same cycle, so the core does not commit). If cpu_valid: latch addr/wstrb/wdata into bus_* registers, go BUSY. Else stay.
- BUSY: bus_valid=1 (registered); cpu_stall=1. bus_addr/bus_wstrb/bus_wdata stable until handshake. On bus_valid && bus_ready: if bus_wstrb==0, cpu_rdata<=bus_rdata; writes leave cpu_rdata unchanged; bus_valid<=0; go DONE.
- DONE: exactly one cycle; cpu_stall=0; core commits using cpu_rdata; cpu_valid ignored this cycle (same instruction still presented, must not reissue). Go IDLE.
- Minimum latency: request in cycle T, bus_valid at T+1, ready at T+1 -> DONE at T+2; core stalls 2 cycles. Each extra bus wait cycle adds one stall cycle.
- cpu_rdata holds its value between transactions.
- bus_valid never drops before bus_ready (except reset/timeout abort).
- cpu_stall never asserted in DONE or in IDLE with cpu_valid=0.
- Back-to-back memory instructions: request re-detected in the IDLE cycle after DONE; no bubble beyond IDLE detection.
- Core sync reset while bridge BUSY: bridge completes the bus transaction normally; core ignores stall during its reset.
- cpu_addr/cpu_wdata sampled only on IDLE->BUSY; changes afterwards ignored.

Optional Feature:
DMEM_BRIDGE_TIMEOUT_EN. Defined: 16-bit watchdog cleared on entry to BUSY, increments each BUSY cycle without bus_ready; when it reaches TIMEOUT_CYCLES with no handshake: bus_valid<=0, cpu_rdata<=ERR_RDATA (reads only), bus_err pulses 1 cycle, go DONE. Handshake in the same cycle as the limit wins (normal completion, no bus_err). Undefined: no counter, bus_err tied 0, BUSY waits indefinitely.

Test Plan:
- Reset: hold resetn=0 with cpu_valid=1 -> cpu_stall=1 comb only, bus_valid=0, cpu_rdata=0; release -> BUSY next cycle.
- Read, zero wait: cpu_valid=1, wstrb=0, addr=32'h100; bus_ready=1, bus_rdata=32'h1234_5678 at T+1 -> stall high T,T+1, low T+2, cpu_rdata=32'h1234_5678 at T+2, bus_addr=32'h100.
- Write, 3 wait cycles: wstrb=4'b0011, wdata=32'hAAAA_5555, bus_ready at T+4 -> bus_valid T+1..T+4, wstrb/wdata stable, DONE T+5, cpu_rdata unchanged.
- Back-to-back: SW then LW, cpu_valid held across -> exactly two bus transactions, no duplicate issue in DONE cycle.
- Async reset mid-BUSY: resetn low at T+2 while waiting -> bus_valid=0 same cycle, state IDLE, no DONE.
- Timeout (feature on, TIMEOUT_CYCLES=4): read, bus_ready never -> after 4 BUSY cycles bus_err=1 one cycle, cpu_rdata=32'hDEAD_BEEF, stall released next cycle.
